// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared types and sizing helpers for seq_digit_adder
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit so DIGIT == WIDTH still works.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_fa.sv
// rtl/digit_fa.sv - combinational DIGIT-bit ripple adder slice
module digit_fa #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Full slice sum; the carry into the top bit is recovered from the top bit's XOR identity.
  always_comb begin
    {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    c_msb   = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
  end

endmodule

// File: rtl/seq_digit_adder.sv
// rtl/seq_digit_adder.sv - digit-serial adder with valid/ready handshakes; SEQ_ADDER_SUB_EN adds the op (subtract) port
module seq_digit_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef SEQ_ADDER_SUB_EN
  ,
  input  logic             op
`endif
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             carry, cout_r, ovf_r;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT-1:0] fa_s;
  logic             fa_co, fa_c_msb;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic             last_dig;

  digit_fa #(.DIGIT(DIGIT)) u_fa (
    .x     (a_sh[DIGIT-1:0]),
    .y     (b_sh[DIGIT-1:0]),
    .ci    (carry),
    .s     (fa_s),
    .co    (fa_co),
    .c_msb (fa_c_msb)
  );

  // Operand conditioning at acceptance: subtraction is A + ~B + 1.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SEQ_ADDER_SUB_EN
    if (op) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // New digit enters the top of the sum register, older digits slide down.
  always_comb begin
    sum_cat  = {fa_s, sum_r};
    last_dig = (cnt == LAST_DIG);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs, decoded from state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_dig) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on acceptance, then one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          sum_r <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (last_dig) begin
            cout_r <= fa_co;
            ovf_r  <= fa_c_msb ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_seq_digit_adder.sv
// tb/tb_seq_digit_adder.sv - directed and random checks of seq_digit_adder (DIGIT=4 and DIGIT=1)
module tb_seq_digit_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv4 = 0, ir4, ov4, or4 = 0, cin4 = 0, co4, of4;
  logic [11:0] a4 = 0, b4 = 0, s4;
  logic        iv1 = 0, ir1, ov1, or1 = 0, cin1 = 0, co1, of1;
  logic [11:0] a1 = 0, b1 = 0, s1;
`ifdef SEQ_ADDER_SUB_EN
  logic        op4 = 0, op1 = 0;
`endif

  int total = 0;
  int bad   = 0;

  seq_digit_adder #(.WIDTH(12), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
`ifdef SEQ_ADDER_SUB_EN
    , .op(op4)
`endif
  );

  seq_digit_adder #(.WIDTH(12), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
`ifdef SEQ_ADDER_SUB_EN
    , .op(op1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands to dut4, scramble them after acceptance, measure edges until out_valid.
  task automatic start4(input logic [11:0] av, input logic [11:0] bv, input logic cv,
                        input logic opv, output int lat);
    int g;
    @(posedge clk); #1;
    a4 = av; b4 = bv; cin4 = cv; iv4 = 1'b1;
`ifdef SEQ_ADDER_SUB_EN
    op4 = opv;
`else
    if (opv) cin4 = cv;
`endif
    g = 0;
    while (!ir4 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 12'($urandom); b4 = 12'($urandom); cin4 = ~cv;
`ifdef SEQ_ADDER_SUB_EN
    op4 = ~opv;
`endif
    lat = 0;
    while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop4(input string tag);
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    chk({tag, "_ov_low"}, ov4, 1'b0);
    chk({tag, "_ir_high"}, ir4, 1'b1);
  endtask

  task automatic op_check4(input string tag, input logic [11:0] av, input logic [11:0] bv,
                           input logic cv, input logic opv, input logic [11:0] es,
                           input logic ec, input logic eo);
    int lat;
    start4(av, bv, cv, opv, lat);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_sum"}, s4, es);
    chk({tag, "_cout"}, co4, ec);
    chk({tag, "_ovf"}, of4, eo);
    pop4(tag);
  endtask

  initial begin
    int          lat;
    logic [11:0] ra, rb, rbb, es;
    logic        rc, rcc, ec, eo, rop;

    // Reset state, with in_valid asserted to show it is ignored.
    iv4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", ir4, 1'b1);
    chk("rst_ov", ov4, 1'b0);
    chk("rst_sum", s4, 12'h000);
    chk("rst_cout", co4, 1'b0);
    chk("rst_ovf", of4, 1'b0);
    iv4 = 1'b0;
    rst_n = 1'b1;

    op_check4("wrap", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    op_check4("sovf", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
    op_check4("cin1", 12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0);
    op_check4("negovf", 12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    op_check4("cinwrap", 12'hFFF, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);

    // Backpressure: result held and no acceptance for 5 stalled cycles.
    start4(12'h123, 12'h456, 1'b1, 1'b0, lat);
    chk("hold_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      iv4 = 1'b1; a4 = 12'($urandom); b4 = 12'($urandom);
      @(posedge clk); #1;
      chk("hold_ov", ov4, 1'b1);
      chk("hold_ir", ir4, 1'b0);
      chk("hold_sum", s4, 12'h57A);
      chk("hold_cf", {co4, of4}, 2'b00);
    end
    iv4 = 1'b0;
    pop4("hold");

    // Reset during the second RUN cycle discards the operation.
    @(posedge clk); #1;
    a4 = 12'hABC; b4 = 12'h111; cin4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", ov4, 1'b0);
    chk("mid_rst_ir", ir4, 1'b1);
    chk("mid_rst_sum", s4, 12'h000);
    iv4 = 1'b1;
    @(posedge clk); #1;
    chk("rst_ignore_iv", ir4, 1'b1);
    iv4 = 1'b0;
    rst_n = 1'b1;
    op_check4("after_rst", 12'h001, 12'h002, 1'b0, 1'b0, 12'h003, 1'b0, 1'b0);

`ifdef SEQ_ADDER_SUB_EN
    op_check4("sub_neg", 12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
    op_check4("sub_ovf", 12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
    op_check4("sub_cin_ign", 12'h010, 12'h010, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0);
`endif

    // DIGIT=1 instance: random operands with random output backpressure.
    for (int n = 0; n < 1000; n++) begin
      ra = 12'($urandom); rb = 12'($urandom); rc = 1'($urandom); rop = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      rop = 1'($urandom);
      op1 = rop;
`endif
      rbb = rop ? ~rb : rb;
      rcc = rop ? 1'b1 : rc;
      {ec, es} = {1'b0, ra} + {1'b0, rbb} + {12'd0, rcc};
      eo = (ra[11] == rbb[11]) && (es[11] != ra[11]);
      @(posedge clk); #1;
      a1 = ra; b1 = rb; cin1 = rc; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0; a1 = 12'($urandom); b1 = 12'($urandom); cin1 = ~rc;
      lat = 0;
      while (!ov1 && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("d1_lat", lat, 12);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      chk("d1_result", {of1, co1, s1}, {eo, ec, es});
      or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
      chk("d1_ir", ir1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
